mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
- Parametrised, runtime-programmable modulus-N counter. Successor to the fixed mod-6 counter.
- Counts up or down, supports synchronous load and enable, and produces a cascade carry/borrow so instances can be chained into multi-digit counters (e.g. mod-10 / mod-6 time-of-day chains).
- Used as a generic divider/sequencer building block across the counters library.

Parameters:
- WIDTH, 4, counter and modulus width in bits (>=2).
- DEFAULT_MOD, 6, modulus loaded at reset; legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; also gates cascade input (chain: en of next stage = co of previous)
- up_dn  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- mod_wr  input  1  synchronous write of new modulus
- mod_val  input  WIDTH  new modulus value
- q  output  WIDTH  current count, registered
- co  output  1  combinational carry/borrow: en & (up_dn ? q==mod-1 : q==0)
- mod  output  WIDTH  current modulus register
- err  output  1  registered one-cycle pulse on rejected modulus write or clamped load

Behaviour:
- Reset (async, rst=1): q=0, mod=DEFAULT_MOD, err=0. co is therefore 0 (en low) or follows its equation immediately after reset. Reset mid-count aborts immediately; no pending operation survives.
- Per-cycle priority: mod_wr update evaluated first, then load, then count. All take effect at the same clock edge.
- mod_wr=1:
  - If mod_val is in 2..2^WIDTH-1: mod <= mod_val.
  - Else (mod_val 0 or 1): mod unchanged, err=1 next cycle.
  - If the accepted new mod <= current q, and no load occurs this cycle: q <= 0.
- load=1:
  - Compare load_val against the effective modulus (new mod if accepted this cycle, else current).
  - If load_val < mod: q <= load_val.
  - Else: q <= mod-1, err=1 next cycle.
  - load overrides counting regardless of en.
- Counting (no load, en=1):
  - Up: q <= (q==mod-1) ? 0 : q+1.
  - Down: q <= (q==0) ? mod-1 : q-1.
  - en=0: q holds.
- Cascade semantics:
  - co is high in the cycle where the next enabled edge wraps q.
  - co is purely combinational from q, mod, en and up_dn; no latency.
  - A chained stage advances on the same edge as the wrap.
- Direction change takes effect on the next enabled edge; no extra cycle.
- Out-of-range q (q >= mod) is unreachable by construction. If forced (e.g. by X-injection), the next enabled up-count wraps to 0.
- err is a single-cycle pulse. Back-to-back errors keep it high for consecutive cycles. err=0 otherwise.
- No combinational path from load_val/mod_val to any output.

Optional Feature:
- WRAP_COUNT_EN defined: adds an output port wraps [15:0].
  - Increments (saturating at 16'hFFFF) on every enabled edge where co=1 and load=0.
  - Reset to 0 by rst.
  - mod_wr and load do not clear it.
- WRAP_COUNT_EN undefined: port and logic are absent. All other behaviour is identical.

Test Plan (WIDTH=4, DEFAULT_MOD=6):
- rst pulse, then en=1, up_dn=1 for 13 edges -> q: 1,2,3,4,5,0,1,2,3,4,5,0,1; co high when q=5; err stays 0.
- up_dn=0 from q=0, en=1, 3 edges -> q: 5,4,3; co high only while q=0.
- At q=4: mod_wr=1, mod_val=3 -> next cycle mod=3, q=0. Then mod_wr with mod_val=1 -> mod stays 3, err pulses one cycle.
- mod=10: load=1, load_val=7 with en=0 -> q=7. Then load_val=12 -> q=9, err pulses one cycle.
- Two instances chained (mod 10, then mod 6; co0->en1), en0=1 for 60 edges -> stage1 increments every 10 edges, both return to 0 at edge 60; assert rst at edge 37 -> both q=0 immediately, asynchronously.
- With WRAP_COUNT_EN defined: mod=2, 10 enabled up edges -> wraps=5. Without the macro, the bench confirms the port is absent by compiling without the macro.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Runtime-programmable modulus-N up/down counter with sync load, enable and cascade carry/borrow.
// Define WRAP_COUNT_EN to add a saturating 16-bit wrap counter output 'wraps'.
module mod_n_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic [WIDTH-1:0] mod,
  output logic             err
`ifdef WRAP_COUNT_EN
  ,
  output logic [15:0]      wraps
`endif
);

  logic             mod_ok;
  logic             mod_rej;
  logic [WIDTH-1:0] mod_eff;
  logic             clamp;
  logic [WIDTH-1:0] q_next;

  // A modulus write of 0 or 1 is rejected; load and count use the modulus that will hold after this edge.
  assign mod_ok  = mod_val > WIDTH'(1);
  assign mod_rej = mod_wr & ~mod_ok;
  assign mod_eff = (mod_wr && mod_ok) ? mod_val : mod;
  assign clamp   = load & (load_val >= mod_eff);

  assign co = en & (up_dn ? (q == mod - WIDTH'(1)) : (q == '0));

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = clamp ? mod_eff - WIDTH'(1) : load_val;
    end else if (mod_wr && mod_ok && (mod_val <= q)) begin
      q_next = '0;
    end else if (en) begin
      // Using >= lets a forced out-of-range count recover by wrapping to 0.
      if (up_dn)
        q_next = (q >= mod_eff - WIDTH'(1)) ? '0 : q + WIDTH'(1);
      else
        q_next = (q == '0) ? mod_eff - WIDTH'(1) : q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      mod <= WIDTH'(DEFAULT_MOD);
      err <= 1'b0;
    end else begin
      q   <= q_next;
      err <= mod_rej | clamp;
      if (mod_wr && mod_ok)
        mod <= mod_val;
    end
  end

`ifdef WRAP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wraps <= '0;
    else if (co && !load && (wraps != 16'hFFFF))
      wraps <= wraps + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: directed vector table plus chain and async-reset sequences.
// Builds with or without WRAP_COUNT_EN; the wrap counter is only checked when the macro is defined.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, load = 1'b0, mod_wr = 1'b0;
  logic [3:0] load_val = '0, mod_val = '0;
  logic [3:0] q0, mod0, q1, mod1;
  logic       co0, err0, co1, err1;
`ifdef WRAP_COUNT_EN
  logic [15:0] wraps0, wraps1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(4), .DEFAULT_MOD(6)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .mod_wr(mod_wr), .mod_val(mod_val), .q(q0), .co(co0), .mod(mod0), .err(err0)
`ifdef WRAP_COUNT_EN
    , .wraps(wraps0)
`endif
  );

  // Second stage of the chain: enabled by the first stage's carry.
  mod_n_updown_counter #(.WIDTH(4), .DEFAULT_MOD(6)) dut1 (
    .clk(clk), .rst(rst), .en(co0), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .mod_wr(1'b0), .mod_val(4'd0), .q(q1), .co(co1), .mod(mod1), .err(err1)
`ifdef WRAP_COUNT_EN
    , .wraps(wraps1)
`endif
  );

  typedef struct {
    logic       en, up_dn, load;
    logic [3:0] load_val;
    logic       mod_wr;
    logic [3:0] mod_val;
    logic [3:0] exp_q;
    logic       exp_co;
    logic [3:0] exp_mod;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic u, logic ld, logic [3:0] lv, logic mw, logic [3:0] mv,
                              logic [3:0] eq, logic ec, logic [3:0] em, logic ee);
    vec_t v;
    v.en = e; v.up_dn = u; v.load = ld; v.load_val = lv; v.mod_wr = mw; v.mod_val = mv;
    v.exp_q = eq; v.exp_co = ec; v.exp_mod = em; v.exp_err = ee;
    return v;
  endfunction

  task automatic applyStimulus(input logic e, input logic u, input logic ld, input logic [3:0] lv,
                               input logic mw, input logic [3:0] mv);
    @(negedge clk);
    en = e; up_dn = u; load = ld; load_val = lv; mod_wr = mw; mod_val = mv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_q0", 16'(q0), 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int up_seq[13] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};

    foreach (up_seq[i])
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 4'(up_seq[i]), up_seq[i] == 5, 6, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 1, 6, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  5, 0, 6, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  4, 0, 6, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  3, 0, 6, 0));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0,  4, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 3,  0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 1,  0, 0, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 10, 0, 0, 10, 0));
    vecs.push_back(mk(0, 1, 1, 7,  0, 0,  7, 0, 10, 0));
    vecs.push_back(mk(0, 1, 1, 12, 0, 0,  9, 0, 10, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  9, 0, 10, 0));
    vecs.push_back(mk(0, 1, 1, 7,  1, 5,  4, 0, 5, 1));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 0,  0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 0, 0,  1, 0,  0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 4,  0, 0,  4, 0, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 3,  0, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 2,  0, 0,  2, 1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  1, 0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  2, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  2, 0, 3, 0));

    do_reset();
    checkOutput("reset_q",   16'(q0),   16'd0);
    checkOutput("reset_mod", 16'(mod0), 16'd6);
    checkOutput("reset_err", 16'(err0), 16'd0);
    checkOutput("reset_co",  16'(co0),  16'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_val,
                    vecs[i].mod_wr, vecs[i].mod_val);
      step();
      checkOutput($sformatf("vec%0d_q", i),   16'(q0),   16'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_co", i),  16'(co0),  16'(vecs[i].exp_co));
      checkOutput($sformatf("vec%0d_mod", i), 16'(mod0), 16'(vecs[i].exp_mod));
      checkOutput($sformatf("vec%0d_err", i), 16'(err0), 16'(vecs[i].exp_err));
    end

    // Two-stage mod-10 / mod-6 chain over a full 60-count period.
    do_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd10);
    step();
    checkOutput("chain_mod0", 16'(mod0), 16'd10);
    checkOutput("chain_mod1", 16'(mod1), 16'd6);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 1; k <= 60; k++) begin
      step();
      checkOutput($sformatf("chain%0d_q0", k), 16'(q0), 16'(k % 10));
      checkOutput($sformatf("chain%0d_q1", k), 16'(q1), 16'((k / 10) % 6));
    end

    // Asynchronous reset in the middle of a cycle after 37 more edges.
    for (int k = 1; k <= 37; k++)
      step();
    checkOutput("pre_rst_q0", 16'(q0), 16'd7);
    checkOutput("pre_rst_q1", 16'(q1), 16'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_q0",   16'(q0),   16'd0);
    checkOutput("midrst_q1",   16'(q1),   16'd0);
    checkOutput("midrst_mod0", 16'(mod0), 16'd6);
    @(negedge clk);
    rst = 1'b0;

`ifdef WRAP_COUNT_EN
    do_reset();
    checkOutput("wraps_reset", wraps0, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 1; k <= 10; k++)
      step();
    checkOutput("wraps_count", wraps0, 16'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 4'd3);
    step();
    checkOutput("wraps_keep", wraps0, 16'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
